// File: rtl/trap_sequencer.sv
// Trap controller: arbitrates exception sources, writes mepc/mcause/mtval one per cycle,
// then flushes and redirects fetch to the trap vector (or to mepc on mret).
module trap_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        xb_illegal,
  input  logic [31:0] xb_pc,
  input  logic [31:0] xb_inst,
  input  logic        fd_unsupported,
  input  logic        fd_illegal,
  input  logic        fd_inst_misaligned,
  input  logic        fd_mem_misaligned,
  input  logic        fd_mem_store,
  input  logic [31:0] fd_pc,
  input  logic [31:0] fd_inst,
  input  logic [31:0] fd_target,
  input  logic [31:0] fd_mem_addr,
  input  logic        mret,
  input  logic [31:0] csr_mepc,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        csr_we,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SAVE_EPC   = 3'd1,
    SAVE_CAUSE = 3'd2,
    SAVE_TVAL  = 3'd3,
    REDIRECT   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_s;
  logic        exc_s;
  logic [31:0] sel_epc_s;
  logic [4:0]  sel_cause_s;
  logic [31:0] sel_tval_s;
  logic [31:0] epc_r;
  logic [4:0]  cause_r;
  logic [31:0] tval_r;
  logic        csr_we_s;
  logic [11:0] csr_addr_s;
  logic [31:0] csr_wdata_s;
  logic        redirect_valid_s;
  logic [31:0] redirect_pc_s;
  logic        csr_we_r;
  logic [11:0] csr_addr_r;
  logic [31:0] csr_wdata_r;
  logic        redirect_valid_r;
  logic [31:0] redirect_pc_r;

  assign exc_s = xb_illegal | fd_unsupported | fd_illegal | fd_inst_misaligned | fd_mem_misaligned;

  // Fixed-priority source selection: XB stage first, then FD categories in order.
  always_comb begin
    sel_epc_s   = fd_pc;
    sel_cause_s = 5'd0;
    sel_tval_s  = 32'h0000_0000;
    if (xb_illegal) begin
      sel_epc_s   = xb_pc;
      sel_cause_s = 5'd2;
      sel_tval_s  = xb_inst;
    end else if (fd_unsupported | fd_illegal) begin
      sel_cause_s = 5'd2;
      sel_tval_s  = fd_inst;
    end else if (fd_inst_misaligned) begin
      sel_cause_s = 5'd0;
      sel_tval_s  = fd_target;
    end else if (fd_mem_misaligned) begin
      sel_cause_s = fd_mem_store ? 5'd6 : 5'd4;
      sel_tval_s  = fd_mem_addr;
    end else begin
      sel_cause_s = 5'd0;
      sel_tval_s  = 32'h0000_0000;
    end
  end

  // Next-state logic; requests are only looked at while idle.
  always_comb begin
    next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (exc_s) begin
          next_s = SAVE_EPC;
        end else if (mret) begin
          next_s = REDIRECT;
        end else begin
          next_s = IDLE;
        end
      end
      SAVE_EPC:   next_s = SAVE_CAUSE;
      SAVE_CAUSE: next_s = SAVE_TVAL;
      SAVE_TVAL:  next_s = REDIRECT;
      REDIRECT:   next_s = IDLE;
      default:    next_s = IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    csr_we_s         = 1'b0;
    csr_addr_s       = 12'h000;
    csr_wdata_s      = 32'h0000_0000;
    redirect_valid_s = 1'b0;
    redirect_pc_s    = 32'h0000_0000;
    case (next_s)
      SAVE_EPC: begin
        // Latch is not loaded yet on the accept edge, so use the live selection.
        csr_we_s    = 1'b1;
        csr_addr_s  = 12'h341;
        csr_wdata_s = {sel_epc_s[31:1], 1'b0};
      end
      SAVE_CAUSE: begin
        csr_we_s    = 1'b1;
        csr_addr_s  = 12'h342;
        csr_wdata_s = {27'd0, cause_r};
      end
      SAVE_TVAL: begin
        csr_we_s    = 1'b1;
        csr_addr_s  = 12'h343;
        csr_wdata_s = tval_r;
      end
      REDIRECT: begin
        redirect_valid_s = 1'b1;
        if (state_r == IDLE) begin
          redirect_pc_s = csr_mepc;
        end else begin
          redirect_pc_s = TRAP_VECTOR;
        end
      end
      default: begin
        csr_we_s         = 1'b0;
        redirect_valid_s = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Trap information captured on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc_r   <= 32'h0000_0000;
      cause_r <= 5'd0;
      tval_r  <= 32'h0000_0000;
    end else if ((state_r == IDLE) && exc_s) begin
      epc_r   <= sel_epc_s;
      cause_r <= sel_cause_s;
      tval_r  <= sel_tval_s;
    end
  end

  // Registered CSR-write and redirect outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      csr_we_r         <= 1'b0;
      csr_addr_r       <= 12'h000;
      csr_wdata_r      <= 32'h0000_0000;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 32'h0000_0000;
    end else begin
      csr_we_r         <= csr_we_s;
      csr_addr_r       <= csr_addr_s;
      csr_wdata_r      <= csr_wdata_s;
      redirect_valid_r <= redirect_valid_s;
      redirect_pc_r    <= redirect_pc_s;
    end
  end

  assign stall          = (state_r != IDLE) | ((state_r == IDLE) & (exc_s | mret));
  assign csr_we         = csr_we_r;
  assign csr_addr       = csr_addr_r;
  assign csr_wdata      = csr_wdata_r;
  assign redirect_valid = redirect_valid_r;
  assign flush          = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: per-cycle expected outputs are queued when a
// request is driven and popped/compared one per cycle afterwards.
module tb_trap_sequencer;

  logic        clk;
  logic        reset;
  logic        xb_illegal;
  logic [31:0] xb_pc;
  logic [31:0] xb_inst;
  logic        fd_unsupported;
  logic        fd_illegal;
  logic        fd_inst_misaligned;
  logic        fd_mem_misaligned;
  logic        fd_mem_store;
  logic [31:0] fd_pc;
  logic [31:0] fd_inst;
  logic [31:0] fd_target;
  logic [31:0] fd_mem_addr;
  logic        mret;
  logic [31:0] csr_mepc;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] pc;
    logic        st;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  trap_sequencer #(.TRAP_VECTOR(32'h0000_0000)) dut (
    .clk                (clk),
    .reset              (reset),
    .xb_illegal         (xb_illegal),
    .xb_pc              (xb_pc),
    .xb_inst            (xb_inst),
    .fd_unsupported     (fd_unsupported),
    .fd_illegal         (fd_illegal),
    .fd_inst_misaligned (fd_inst_misaligned),
    .fd_mem_misaligned  (fd_mem_misaligned),
    .fd_mem_store       (fd_mem_store),
    .fd_pc              (fd_pc),
    .fd_inst            (fd_inst),
    .fd_target          (fd_target),
    .fd_mem_addr        (fd_mem_addr),
    .mret               (mret),
    .csr_mepc           (csr_mepc),
    .stall              (stall),
    .flush              (flush),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .csr_we             (csr_we),
    .csr_addr           (csr_addr),
    .csr_wdata          (csr_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    xb_illegal = 1'b0; xb_pc = 32'h0; xb_inst = 32'h0;
    fd_unsupported = 1'b0; fd_illegal = 1'b0; fd_inst_misaligned = 1'b0;
    fd_mem_misaligned = 1'b0; fd_mem_store = 1'b0;
    fd_pc = 32'h0; fd_inst = 32'h0; fd_target = 32'h0; fd_mem_addr = 32'h0;
    mret = 1'b0; csr_mepc = 32'h0;
  endtask

  task automatic push_cycle(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic rv, input logic [31:0] pc, input logic st);
    exp_t x;
    x.we = we; x.addr = addr; x.wdata = wdata; x.rv = rv; x.pc = pc; x.st = st;
    sb_q.push_back(x);
  endtask

  // Expected cycles N+1..N+4 of an exception sequence (trap vector is 0).
  task automatic push_trap(input logic [31:0] epc, input logic [4:0] cause, input logic [31:0] tval);
    push_cycle(1'b1, 12'h341, {epc[31:1], 1'b0}, 1'b0, 32'h0, 1'b1);
    push_cycle(1'b1, 12'h342, {27'd0, cause}, 1'b0, 32'h0, 1'b1);
    push_cycle(1'b1, 12'h343, tval, 1'b0, 32'h0, 1'b1);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; sb_q.size() > 0; k++) begin
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL reset cyc%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fd_load();
    fd_mem_misaligned = 1'b1; fd_mem_store = 1'b0; fd_pc = 32'h100; fd_mem_addr = 32'h2003;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL fd_load_stall_req got %b want 1", stall);
    end
    push_trap(32'h100, 5'd4, 32'h2003);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        clear_inputs();
        fd_mem_addr = 32'hFFFF_0000; // must not disturb the latched tval
      end
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL fd_load N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    xb_illegal = 1'b1; xb_pc = 32'h40; xb_inst = 32'h3020_0073;
    fd_inst_misaligned = 1'b1; fd_pc = 32'h44; fd_target = 32'h99;
    push_trap(32'h40, 5'd2, 32'h3020_0073);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL arbitration N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
  endtask

  task automatic test_inst_misaligned();
    @(negedge clk);
    fd_inst_misaligned = 1'b1; fd_pc = 32'h0000_0A03; fd_target = 32'h0000_1235;
    fd_inst = 32'h0000_006F;
    push_trap(32'h0000_0A02, 5'd0, 32'h0000_1235);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL inst_misaligned N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
  endtask

  task automatic test_mret();
    @(negedge clk);
    mret = 1'b1; csr_mepc = 32'h208;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL mret_stall_req got %b want 1", stall);
    end
    push_cycle(1'b0, 12'h000, 32'h0, 1'b1, 32'h208, 1'b1);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        clear_inputs();
        csr_mepc = 32'h0000_0BAD;
      end
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL mret N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
    clear_inputs();
  endtask

  task automatic test_mret_with_exc();
    @(negedge clk);
    mret = 1'b1; csr_mepc = 32'h208;
    fd_illegal = 1'b1; fd_pc = 32'h600; fd_inst = 32'h1234_5678;
    push_trap(32'h600, 5'd2, 32'h1234_5678);
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL mret_exc N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
  endtask

  // hold_through=0: request raised in SAVE_CAUSE and dropped before IDLE.
  // hold_through=1: request held into IDLE, second sequence accepted at end of N+5.
  task automatic test_busy(input bit hold_through);
    @(negedge clk);
    fd_mem_misaligned = 1'b1; fd_mem_store = 1'b1; fd_pc = 32'h301; fd_mem_addr = 32'h55;
    push_trap(32'h300, 5'd6, 32'h55);
    if (hold_through) begin
      push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1);
      push_trap(32'h500, 5'd2, 32'h0000_DEAD);
    end else begin
      push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    end
    push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      if (k == 2) begin
        fd_illegal = 1'b1; fd_pc = 32'h500; fd_inst = 32'h0000_DEAD;
      end
      if ((k == 4 && !hold_through) || (k == 6 && hold_through)) clear_inputs();
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL busy%0d N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 hold_through, k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_trap();
    @(negedge clk);
    xb_illegal = 1'b1; xb_pc = 32'h80; xb_inst = 32'hFFFF_FFFF;
    push_cycle(1'b1, 12'h341, 32'h80, 1'b0, 32'h0, 1'b1);
    push_cycle(1'b1, 12'h342, 32'h2, 1'b0, 32'h0, 1'b1);
    repeat (3) push_cycle(1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int k = 1; sb_q.size() > 0; k++) begin
      @(negedge clk);
      if (k == 1) clear_inputs();
      if (k == 2) reset = 1'b1;
      if (k == 3) reset = 1'b0;
      #1;
      e = sb_q.pop_front();
      checks++;
      if ({csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall} !==
          {e.we, e.addr, e.wdata, e.rv, e.pc, e.rv, e.st}) begin
        errors++;
        $display("FAIL reset_mid N+%0d got we=%b a=%h d=%h rv=%b pc=%h fl=%b st=%b want we=%b a=%h d=%h rv=%b pc=%h st=%b",
                 k, csr_we, csr_addr, csr_wdata, redirect_valid, redirect_pc, flush, stall,
                 e.we, e.addr, e.wdata, e.rv, e.pc, e.st);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_fd_load();
    test_arbitration();
    test_inst_misaligned();
    test_mret();
    test_mret_with_exc();
    test_busy(1'b0);
    test_busy(1'b1);
    test_reset_mid_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
